// File: rtl/ov7670_pkg.sv
// Shared types and defaults for the OV7670 pixel capture path.
package ov7670_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        S_WAIT_CFG,
        S_WAIT_VS,
        S_WAIT_FR,
        S_FRAME
    } cap_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // The camera sends the high byte of each RGB565 word first.
    function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return rgb565_t'({hi, lo});
    endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Pixel write bus from the capture block to the frame-buffer writer.
interface ov7670_capture_if
    import ov7670_pkg::*;
#(
    parameter int ADDR_W = 19
);
    logic              pix_valid;
    rgb565_t           pix_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              frame_start;
    logic              frame_done;
    logic              frame_ok;
    logic              line_err;

    modport master (
        output pix_valid, pix_data, wr_addr, frame_start, frame_done, frame_ok, line_err
    );

    modport slave (
        input pix_valid, pix_data, wr_addr, frame_start, frame_done, frame_ok, line_err
    );
endinterface

// File: rtl/ov7670_capture_cam_sync.sv
// Two-flop synchroniser for a bundle of asynchronous camera pins.
module cam_sync #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);
    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q;
endmodule

// File: rtl/ov7670_capture.sv
// OV7670 frame capture: locks to VSYNC/HREF framing after SCCB configuration and
// emits one RGB565 write (data + linear address) per assembled pixel.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = 19
) (
    input  logic             xclk,
    input  logic             reset_n,
    input  logic             config_done,
    input  logic             capture_en,
    input  logic             cam_pclk,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_d,
    ov7670_capture_if.master pix_if
);
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 2);
    localparam logic [XW-1:0]     X_FULL = XW'(H_ACTIVE);
    localparam logic [YW-1:0]     Y_DONE = YW'(V_ACTIVE);
    localparam logic [YW-1:0]     Y_SAT  = YW'(V_ACTIVE + 1);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

    logic [10:0] sync_w;
    logic        pclk_s, vsync_s, href_s;
    logic [7:0]  d_s;

    cam_sync #(.WIDTH(11)) u_cam_sync (
        .clk     (xclk),
        .reset_n (reset_n),
        .async_i ({cam_pclk, cam_vsync, cam_href, cam_d}),
        .sync_o  (sync_w)
    );

    assign {pclk_s, vsync_s, href_s, d_s} = sync_w;

    cap_state_t        state_d, state_q;
    logic              pclk_prev_d, pclk_prev_q;
    logic              vsync_prev_d, vsync_prev_q;
    logic              href_prev_d, href_prev_q;
    logic [XW-1:0]     x_d, x_q;
    logic [YW-1:0]     y_d, y_q;
    logic [ADDR_W-1:0] line_base_d, line_base_q;
    logic              phase_d, phase_q;
    logic [7:0]        hi_d, hi_q;
    logic              any_byte_d, any_byte_q;
    logic              ovf_d, ovf_q;
    logic              frame_err_d, frame_err_q;
    logic              first_d, first_q;
    logic              pix_valid_d, pix_valid_q;
    rgb565_t           pix_data_d, pix_data_q;
    logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
    logic              frame_start_d, frame_start_q;
    logic              frame_done_d, frame_done_q;
    logic              frame_ok_d, frame_ok_q;
    logic              line_err_d, line_err_q;

    logic pe, vs_rise, vs_fall, href_fall, byte_ev, line_end, in_range;

    assign pe        = pclk_s & ~pclk_prev_q;
    assign vs_rise   = vsync_s & ~vsync_prev_q;
    assign vs_fall   = ~vsync_s & vsync_prev_q;
    assign href_fall = ~href_s & href_prev_q;
    assign byte_ev   = pe & href_s;
    assign line_end  = href_fall & any_byte_q;
    assign in_range  = (y_q < Y_DONE);

    always_comb begin
        state_d       = state_q;
        pclk_prev_d   = pclk_s;
        vsync_prev_d  = vsync_s;
        href_prev_d   = href_s;
        x_d           = x_q;
        y_d           = y_q;
        line_base_d   = line_base_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        any_byte_d    = any_byte_q;
        ovf_d         = ovf_q;
        frame_err_d   = frame_err_q;
        first_d       = first_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        wr_addr_d     = wr_addr_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_ok_d    = 1'b0;
        line_err_d    = 1'b0;

        case (state_q)
            S_WAIT_CFG: begin
                if (config_done) state_d = S_WAIT_VS;
            end
            S_WAIT_VS: begin
                if (vs_rise && capture_en) state_d = S_WAIT_FR;
            end
            S_WAIT_FR: begin
                if (vs_fall) begin
                    state_d     = S_FRAME;
                    x_d         = '0;
                    y_d         = '0;
                    line_base_d = '0;
                    phase_d     = 1'b0;
                    any_byte_d  = 1'b0;
                    ovf_d       = 1'b0;
                    frame_err_d = 1'b0;
                    first_d     = 1'b1;
                end
            end
            S_FRAME: begin
                if (byte_ev) begin
                    any_byte_d = 1'b1;
                    if (first_q) begin
                        frame_start_d = 1'b1;
                        first_d       = 1'b0;
                    end
                    // Lines past the last active row are consumed silently.
                    if (in_range) begin
                        if (x_q == X_FULL) begin
                            if (!ovf_q) line_err_d = 1'b1;
                            ovf_d = 1'b1;
                        end else if (!phase_q) begin
                            hi_d    = d_s;
                            phase_d = 1'b1;
                        end else begin
                            pix_valid_d = 1'b1;
                            pix_data_d  = pack_rgb565(hi_q, d_s);
                            wr_addr_d   = line_base_q + ADDR_W'(x_q);
                            x_d         = x_q + 1'b1;
                            phase_d     = 1'b0;
                        end
                    end
                end
                if (line_end) begin
                    if (in_range && (phase_q || (x_q != X_FULL))) line_err_d = 1'b1;
                    if (in_range) line_base_d = line_base_q + H_STEP;
                    if (y_q != Y_SAT) y_d = y_q + 1'b1;
                    x_d        = '0;
                    phase_d    = 1'b0;
                    any_byte_d = 1'b0;
                    ovf_d      = 1'b0;
                end
                if (line_err_d) frame_err_d = 1'b1;
                // This VSYNC rise also serves as the arming edge for the next frame.
                if (vs_rise) begin
                    frame_done_d = 1'b1;
                    frame_ok_d   = (y_d == Y_DONE) && !frame_err_d;
                    state_d      = capture_en ? S_WAIT_FR : S_WAIT_VS;
                end
            end
            default: state_d = S_WAIT_CFG;
        endcase
    end

    always_ff @(posedge xclk) begin
        if (!reset_n) begin
            state_q       <= S_WAIT_CFG;
            pclk_prev_q   <= 1'b0;
            vsync_prev_q  <= 1'b0;
            href_prev_q   <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_base_q   <= '0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            any_byte_q    <= 1'b0;
            ovf_q         <= 1'b0;
            frame_err_q   <= 1'b0;
            first_q       <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            wr_addr_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pclk_prev_q   <= pclk_prev_d;
            vsync_prev_q  <= vsync_prev_d;
            href_prev_q   <= href_prev_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_base_q   <= line_base_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            any_byte_q    <= any_byte_d;
            ovf_q         <= ovf_d;
            frame_err_q   <= frame_err_d;
            first_q       <= first_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            wr_addr_q     <= wr_addr_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_ok_q    <= frame_ok_d;
            line_err_q    <= line_err_d;
        end
    end

    assign pix_if.pix_valid   = pix_valid_q;
    assign pix_if.pix_data    = pix_data_q;
    assign pix_if.wr_addr     = wr_addr_q;
    assign pix_if.frame_start = frame_start_q;
    assign pix_if.frame_done  = frame_done_q;
    assign pix_if.frame_ok    = frame_ok_q;
    assign pix_if.line_err    = line_err_q;
endmodule
